// File: rtl/mult_16_seq.sv
// mult_16_seq: iterative 16x16 shift-add multiplier with valid/ready handshakes.
// adder_16 is the single partial-product adder used once per CALC cycle.
module adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module mult_16_seq #(
    parameter bit SIGNED = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_m, r_acc_hi, r_acc_lo;
    logic [3:0]  r_cnt;
    logic [31:0] r_product;
    logic        r_out_valid;
    logic        w_sub, w_cin, w_cout, w_msb;
    logic [15:0] w_b, w_s;
    logic [31:0] w_shift;

    // The last signed step weighs the multiplier sign bit negatively, so it subtracts M.
    assign w_sub   = SIGNED && r_cnt == 4'd15 && r_acc_lo[0];
    assign w_b     = w_sub ? ~r_m : (r_acc_lo[0] ? r_m : 16'd0);
    assign w_cin   = w_sub;
    assign w_msb   = SIGNED ? (r_acc_hi[15] ^ w_b[15] ^ w_cout) : w_cout;
    assign w_shift = {w_msb, w_s, r_acc_lo[15:1]};

    adder_16 u_add (
        .a    (r_acc_hi),
        .b    (w_b),
        .cin  (w_cin),
        .s    (w_s),
        .cout (w_cout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? CALC : IDLE;
            CALC:    w_next = (r_cnt == 4'd15) ? DONE : CALC;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_m         <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_m      <= mcand;
                r_acc_hi <= '0;
                r_acc_lo <= mplier;
                r_cnt    <= '0;
            end
            if (r_state == CALC) begin
                {r_acc_hi, r_acc_lo} <= w_shift;
                r_cnt                <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_product   <= w_shift;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == DONE && out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_out_valid;
    assign product   = r_product;
endmodule

// File: tb/tb_mult_16_seq.sv
// tb_mult_16_seq: unsigned and signed instances driven in lockstep, checked against
// directed vectors and plain-arithmetic products.
module tb_mult_16_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] mcand = '0, mplier = '0;
    logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [31:0] product_u, product_s;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_16_seq #(.SIGNED(1'b0)) dut_u (
        .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .mcand(mcand), .mplier(mplier), .out_valid(out_valid_u),
        .out_ready(out_ready), .product(product_u)
    );
    mult_16_seq #(.SIGNED(1'b1)) dut_s (
        .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .mcand(mcand), .mplier(mplier), .out_valid(out_valid_s),
        .out_ready(out_ready), .product(product_s)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] eu;
        logic [31:0] es;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operand pair and runs until both products are valid.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        int n = 0;
        while (!(in_ready_u && in_ready_s) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(n), 32'd0);
        mcand = a;
        mplier = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        mcand = 16'($urandom);
        mplier = 16'($urandom);
        lat = 0;
        while (!(out_valid_u && out_valid_s) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op(input int pct, input logic [31:0] eu, input logic [31:0] es);
        int n = 0;
        logic rdy;
        do begin
            rdy = $urandom_range(0, 99) < pct;
            out_ready = rdy;
            chk("hold_u", product_u, eu);
            chk("hold_s", product_s, es);
            tick();
            n++;
        end while (!rdy && n < 30);
        chk("post_valid", {30'd0, out_valid_u, out_valid_s}, 32'd0);
        chk("post_ready", {30'd0, in_ready_u, in_ready_s}, 32'd3);
    endtask

    initial begin
        int lat;
        logic [31:0] eu, es;
        int es_i;
        tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001};
        tbl[2] = '{16'h0000, 16'hBEEF, 32'h00000000, 32'h00000000};
        tbl[3] = '{16'h8000, 16'h7FFF, 32'h3FFF8000, 32'hC0008000};
        tbl[4] = '{16'h8000, 16'h8000, 32'h40000000, 32'h40000000};
        tbl[5] = '{16'hFFFD, 16'h0007, 32'h0006FFEB, 32'hFFFFFFEB};
        tbl[6] = '{16'h1234, 16'h5678, 32'h06260060, 32'h06260060};
        tbl[7] = '{16'hBEEF, 16'h0000, 32'h00000000, 32'h00000000};

        #12;
        chk("rst_product_u", product_u, 32'd0);
        chk("rst_product_s", product_s, 32'd0);
        chk("rst_flags", {in_ready_u, in_ready_s, out_valid_u, out_valid_s}, 32'hC);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            start_op(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("lat_%0d", i), 32'(lat), 32'd16);
            chk($sformatf("vec_u_%0d", i), product_u, tbl[i].eu);
            chk($sformatf("vec_s_%0d", i), product_s, tbl[i].es);
            finish_op(100, tbl[i].eu, tbl[i].es);
        end

        // Backpressure: product held, busy for 10 cycles, stray in_valid ignored.
        out_ready = 1'b0;
        start_op(16'd3, 16'd5, lat);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            mcand = 16'($urandom);
            mplier = 16'($urandom);
            chk("bp_product", product_u, 32'hF);
            chk("bp_flags", {in_ready_u, in_ready_s, out_valid_u, out_valid_s}, 32'h3);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release", {in_ready_u, in_ready_s, out_valid_u, out_valid_s}, 32'hC);
        chk("bp_keep", product_s, 32'hF);

        // Reset at CALC cycle 7 discards partial work.
        mcand = 16'h1234;
        mplier = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_calc_flags", {in_ready_u, in_ready_s, out_valid_u, out_valid_s}, 32'hC);
        chk("rst_calc_prod", product_u, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_op(16'h1234, 16'h5678, lat);
        chk("rst_lat", 32'(lat), 32'd16);
        chk("rst_prod", product_u, 32'h06260060);

        // Reset during DONE drops out_valid without a clock edge.
        out_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done_flags", {in_ready_u, in_ready_s, out_valid_u, out_valid_s}, 32'hC);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 16 == 0) a = 16'h8000;
            if (i % 16 == 1) b = 16'hFFFF;
            eu = {16'd0, a} * {16'd0, b};
            es_i = $signed(a) * $signed(b);
            es = es_i;
            start_op(a, b, lat);
            chk("rnd_lat", 32'(lat), 32'd16);
            chk("rnd_u", product_u, eu);
            chk("rnd_s", product_s, es);
            finish_op(50, eu, es);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
